vc_wrr_arbiter: RTL and testbench

- Weighted round-robin scheduler sharing the single 6-bit output channel between two virtual-channel FIFOs, VC0 and VC1.
- Decides each cycle which VC FIFO to pop and registers the selected word onto dataout/valid_out.
- Sits between the VC0/VC1 show-ahead FIFOs and the downstream demux/FIFO stage, and honours a downstream pause.

---
 rtl/vc_pkg.sv | 15 +
 rtl/vc_grant_counter.sv | 51 +++++
 rtl/vc_wrr_arbiter.sv | 136 +++++++++++++
 tb/tb_vc_wrr_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/vc_pkg.sv
// Shared types and constants for the two-VC weighted round-robin arbiter.
package vc_pkg;

  localparam int BW_DEFAULT = 6;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SERVE_VC0 = 2'b01,
    SERVE_VC1 = 2'b10
  } state_t;

  localparam logic VC0 = 1'b0;
  localparam logic VC1 = 1'b1;

endpackage

// File: rtl/vc_grant_counter.sv
// Consecutive-grant counter for the VC currently owning the channel,
// flagging when that VC has used up its weight.
module vc_grant_counter
  import vc_pkg::*;
#(
  parameter int WEIGHT_VC0 = 3,
  parameter int WEIGHT_VC1 = 1,
  parameter int CW         = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_one,
  input  logic          incr,
  input  logic          clear,
  input  logic          sel,
  output logic [CW-1:0] cnt,
  output logic          weight_exhausted
);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] weight_s;

  // Counter register; clear dominates, then restart at one, then increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (load_one) begin
      cnt_r <= CW'(1);
    end else if (incr) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Weight of the VC currently being served.
  always_comb begin
    weight_s = CW'(WEIGHT_VC0);
    if (sel == VC1) begin
      weight_s = CW'(WEIGHT_VC1);
    end else begin
      weight_s = CW'(WEIGHT_VC0);
    end
  end

  assign cnt              = cnt_r;
  assign weight_exhausted = (cnt_r >= weight_s);

endmodule

// File: rtl/vc_wrr_arbiter.sv
// Weighted round-robin scheduler popping VC0/VC1 show-ahead FIFOs onto one
// registered output channel, with downstream pause.
module vc_wrr_arbiter
  import vc_pkg::*;
#(
  parameter int BW         = BW_DEFAULT,
  parameter int WEIGHT_VC0 = 3,
  parameter int WEIGHT_VC1 = 1,
  parameter int CW         = $clog2(((WEIGHT_VC0 > WEIGHT_VC1) ? WEIGHT_VC0 : WEIGHT_VC1) + 1)
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          vc0_empty,
  input  logic          vc1_empty,
  input  logic [BW-1:0] data_in_VC0,
  input  logic [BW-1:0] data_in_VC1,
  input  logic          pause,
  output logic          pop_VC0,
  output logic          pop_VC1,
  output logic [BW-1:0] dataout,
  output logic          valid_out,
  output logic          grant_vc
);

  state_t        state_r, state_n_s;
  logic          pop0_s, pop1_s;
  logic          load_s, incr_s, clear_s;
  logic          sel_s;
  logic          exhausted_s;
  logic [CW-1:0] cnt_s;
  logic [BW-1:0] dataout_r;
  logic          valid_r;
  logic          grant_r;

  assign sel_s = (state_r == SERVE_VC1) ? VC1 : VC0;

  vc_grant_counter #(
    .WEIGHT_VC0 (WEIGHT_VC0),
    .WEIGHT_VC1 (WEIGHT_VC1),
    .CW         (CW)
  ) u_cnt (
    .clk              (clk),
    .rst              (reset_L),
    .load_one         (load_s),
    .incr             (incr_s),
    .clear            (clear_s),
    .sel              (sel_s),
    .cnt              (cnt_s),
    .weight_exhausted (exhausted_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Grant decision; reset or pause suppresses every pop and freezes state/cnt.
  always_comb begin
    state_n_s = state_r;
    pop0_s    = 1'b0;
    pop1_s    = 1'b0;
    load_s    = 1'b0;
    incr_s    = 1'b0;
    clear_s   = 1'b0;
    if (reset_L || pause) begin
      state_n_s = state_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (!vc0_empty) begin
            pop0_s = 1'b1; load_s = 1'b1; state_n_s = SERVE_VC0;
          end else if (!vc1_empty) begin
            pop1_s = 1'b1; load_s = 1'b1; state_n_s = SERVE_VC1;
          end else begin
            state_n_s = IDLE;
          end
        end
        SERVE_VC0: begin
          if (!vc0_empty && !exhausted_s) begin
            pop0_s = 1'b1; incr_s = 1'b1;
          end else if (!vc1_empty) begin
            pop1_s = 1'b1; load_s = 1'b1; state_n_s = SERVE_VC1;
          end else if (!vc0_empty) begin
            pop0_s = 1'b1; load_s = 1'b1;
          end else begin
            clear_s = 1'b1; state_n_s = IDLE;
          end
        end
        SERVE_VC1: begin
          if (!vc1_empty && !exhausted_s) begin
            pop1_s = 1'b1; incr_s = 1'b1;
          end else if (!vc0_empty) begin
            pop0_s = 1'b1; load_s = 1'b1; state_n_s = SERVE_VC0;
          end else if (!vc1_empty) begin
            pop1_s = 1'b1; load_s = 1'b1;
          end else begin
            clear_s = 1'b1; state_n_s = IDLE;
          end
        end
        default: begin
          clear_s = 1'b1; state_n_s = IDLE;
        end
      endcase
    end
  end

  // Output register: capture the popped head word one cycle after the pop.
  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) begin
      dataout_r <= {BW{1'b0}};
      valid_r   <= 1'b0;
      grant_r   <= VC0;
    end else if (pop0_s) begin
      dataout_r <= data_in_VC0;
      valid_r   <= 1'b1;
      grant_r   <= VC0;
    end else if (pop1_s) begin
      dataout_r <= data_in_VC1;
      valid_r   <= 1'b1;
      grant_r   <= VC1;
    end else begin
      valid_r   <= 1'b0;
    end
  end

  assign pop_VC0   = pop0_s;
  assign pop_VC1   = pop1_s;
  assign dataout   = dataout_r;
  assign valid_out = valid_r;
  assign grant_vc  = grant_r;

endmodule

// File: tb/tb_vc_wrr_arbiter.sv
// Directed scoreboard bench for vc_wrr_arbiter (weights 3/1).
module tb_vc_wrr_arbiter;

  typedef struct packed {
    logic       valid;
    logic       vc;
    logic [5:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       vc0_empty, vc1_empty;
  logic [5:0] data_in_VC0, data_in_VC1;
  logic       pause;
  logic       pop_VC0, pop_VC1;
  logic [5:0] dataout;
  logic       valid_out;
  logic       grant_vc;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] vcseq = 8'b1000_1000;

  vc_wrr_arbiter #(.BW(6), .WEIGHT_VC0(3), .WEIGHT_VC1(1)) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .vc0_empty   (vc0_empty),
    .vc1_empty   (vc1_empty),
    .data_in_VC0 (data_in_VC0),
    .data_in_VC1 (data_in_VC1),
    .pause       (pause),
    .pop_VC0     (pop_VC0),
    .pop_VC1     (pop_VC1),
    .dataout     (dataout),
    .valid_out   (valid_out),
    .grant_vc    (grant_vc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One stimulus cycle: drive at negedge, check combinational pops, queue the registered result.
  task automatic cyc(input logic e0, input logic e1, input logic [5:0] a, input logic [5:0] b,
                     input logic p, input logic xp0, input logic xp1,
                     input logic xv, input logic xvc, input logic [5:0] xd);
    exp_t e;
    @(negedge clk);
    vc0_empty = e0; vc1_empty = e1; data_in_VC0 = a; data_in_VC1 = b; pause = p;
    #1;
    chk("pop_VC0", {31'd0, pop_VC0}, {31'd0, xp0});
    chk("pop_VC1", {31'd0, pop_VC1}, {31'd0, xp1});
    e.valid = xv; e.vc = xvc; e.data = xd;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    vc0_empty = 1'b1; vc1_empty = 1'b1; pause = 1'b0; reset_L = 1'b1;
    @(negedge clk);
    reset_L = 1'b0;
  endtask

  // Monitor: compare each registered output against the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      chk("valid_out", {31'd0, valid_out}, {31'd0, mon_e.valid});
      chk("grant_vc",  {31'd0, grant_vc},  {31'd0, mon_e.vc});
      chk("dataout",   {26'd0, dataout},   {26'd0, mon_e.data});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_L = 1'b1; vc0_empty = 1'b1; vc1_empty = 1'b1;
    data_in_VC0 = 6'h00; data_in_VC1 = 6'h00; pause = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dataout", {26'd0, dataout}, 32'd0);
    chk("rst_valid",   {31'd0, valid_out}, 32'd0);
    chk("rst_grant",   {31'd0, grant_vc}, 32'd0);
    @(negedge clk);
    reset_L = 1'b0;

    // Both VCs always non-empty: 0,0,0,1 pattern.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 6'(i), 6'(32 + i), 1'b0, ~vcseq[i], vcseq[i], 1'b1, vcseq[i],
          vcseq[i] ? 6'(32 + i) : 6'(i));
    end

    // Only VC1 non-empty, then both empty.
    do_reset();
    cyc(1'b1, 1'b0, 6'h00, 6'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h11);
    cyc(1'b1, 1'b0, 6'h00, 6'h12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h12);
    cyc(1'b1, 1'b0, 6'h00, 6'h13, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h13);
    cyc(1'b1, 1'b1, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h13);

    // Pause after the second VC0 grant keeps the remaining weight.
    do_reset();
    cyc(1'b0, 1'b0, 6'h01, 6'h31, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h01);
    cyc(1'b0, 1'b0, 6'h02, 6'h32, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h02);
    cyc(1'b0, 1'b0, 6'h03, 6'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h02);
    cyc(1'b0, 1'b0, 6'h04, 6'h34, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h02);
    cyc(1'b0, 1'b0, 6'h05, 6'h35, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h05);
    cyc(1'b0, 1'b0, 6'h06, 6'h36, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h36);
    cyc(1'b0, 1'b0, 6'h07, 6'h37, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h07);

    // Both empty after one VC0 word, back to IDLE, then VC1 served with cnt=1.
    do_reset();
    cyc(1'b0, 1'b1, 6'h2A, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h2A);
    cyc(1'b1, 1'b1, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h2A);
    cyc(1'b1, 1'b1, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h2A);
    cyc(1'b1, 1'b0, 6'h00, 6'h35, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h35);
    cyc(1'b0, 1'b0, 6'h0B, 6'h36, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h0B);

    // Asynchronous reset mid-burst.
    do_reset();
    cyc(1'b0, 1'b0, 6'h14, 6'h24, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h14);
    cyc(1'b0, 1'b0, 6'h15, 6'h25, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h15);
    @(posedge clk);
    #3 reset_L = 1'b1;
    #1;
    chk("arst_dataout", {26'd0, dataout}, 32'd0);
    chk("arst_valid",   {31'd0, valid_out}, 32'd0);
    chk("arst_grant",   {31'd0, grant_vc}, 32'd0);
    chk("arst_pop0",    {31'd0, pop_VC0}, 32'd0);
    chk("arst_pop1",    {31'd0, pop_VC1}, 32'd0);
    @(negedge clk);
    vc0_empty = 1'b1; vc1_empty = 1'b1; reset_L = 1'b0;
    cyc(1'b0, 1'b0, 6'h16, 6'h26, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h16);

    // VC0 only: counter restarts at 1 after the third grant, no bubble.
    do_reset();
    cyc(1'b0, 1'b1, 6'h01, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h01);
    cyc(1'b0, 1'b1, 6'h02, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h02);
    cyc(1'b0, 1'b1, 6'h03, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h03);
    cyc(1'b0, 1'b1, 6'h04, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h04);
    cyc(1'b0, 1'b0, 6'h05, 6'h3A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h05);
    cyc(1'b0, 1'b0, 6'h06, 6'h3B, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h06);
    cyc(1'b0, 1'b0, 6'h07, 6'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h3C);

    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
